// File: rtl/hsv_mask_receiver.sv
// Bit-serial HSV pixel receiver: synchronises the Pi stream, classifies each pixel against
// runtime thresholds and stores a 1-bit mask frame. Define HAND_COUNT_EN for the hand-pixel counter.
module hsv_mask_receiver #(
  parameter  int IMG_W       = 40,
  parameter  int IMG_H       = 45,
  parameter  int CH_BITS     = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int PW          = 3 * CH_BITS,
  localparam int NPIX        = IMG_W * IMG_H,
  localparam int AW          = $clog2(NPIX),
  localparam int CW          = $clog2(NPIX + 1),
  localparam int BW          = $clog2(PW)
) (
  input  logic          i_fpga_clk,
  input  logic          i_rst,
  input  logic          i_pi_clk,
  input  logic          i_data_in,
  input  logic          i_write_enable,
  input  logic [PW-1:0] i_thr_min,
  input  logic [PW-1:0] i_thr_max,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_bit,
  output logic [AW-1:0] o_pix_idx,
  output logic          o_frame_done,
  output logic [CW-1:0] o_hand_count
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CLASSIFY} state_t;

  logic [SYNC_STAGES-1:0] r_pclk_sync, r_data_sync, r_we_sync;
  logic                   r_pclk_d;
  logic                   w_pclk, w_data, w_we, w_strobe;

  state_t          r_state;
  logic [PW-1:0]   r_word;
  logic [BW-1:0]   r_bit_cnt;
  logic [AW-1:0]   r_pix_idx;
  logic            r_frame_done;
  logic [NPIX-1:0] r_mask;
  logic            r_rd_bit;
  logic            w_hand, w_last;

  // pi_clk is only a data signal here; all three inputs share the same sync depth so
  // data stays aligned with the clock edge that qualifies it.
  always_ff @(posedge i_fpga_clk) begin
    if (i_rst) begin
      r_pclk_sync <= '0;
      r_data_sync <= '0;
      r_we_sync   <= '0;
      r_pclk_d    <= 1'b0;
    end else begin
      r_pclk_sync <= {r_pclk_sync[SYNC_STAGES-2:0], i_pi_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_data_in};
      r_we_sync   <= {r_we_sync[SYNC_STAGES-2:0], i_write_enable};
      r_pclk_d    <= w_pclk;
    end
  end

  assign w_pclk   = r_pclk_sync[SYNC_STAGES-1];
  assign w_data   = r_data_sync[SYNC_STAGES-1];
  assign w_we     = r_we_sync[SYNC_STAGES-1];
  assign w_strobe = w_pclk & ~r_pclk_d & w_we;

  always_comb begin
    w_hand = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (r_word[c*CH_BITS +: CH_BITS] < i_thr_min[c*CH_BITS +: CH_BITS] ||
          r_word[c*CH_BITS +: CH_BITS] > i_thr_max[c*CH_BITS +: CH_BITS])
        w_hand = 1'b0;
    end
  end

  assign w_last = (r_pix_idx == AW'(NPIX - 1));

`ifdef HAND_COUNT_EN
  logic [CW-1:0] r_hand_count;
  assign o_hand_count = r_hand_count;
`else
  assign o_hand_count = '0;
`endif

  always_ff @(posedge i_fpga_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_bit_cnt    <= '0;
      r_pix_idx    <= '0;
      r_frame_done <= 1'b0;
      r_mask       <= '0;
`ifdef HAND_COUNT_EN
      r_hand_count <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            r_word[0] <= w_data;
            r_bit_cnt <= BW'(1);
            r_state   <= S_SHIFT;
            if (r_frame_done) begin
              r_frame_done <= 1'b0;
              r_pix_idx    <= '0;
`ifdef HAND_COUNT_EN
              r_hand_count <= '0;
`endif
            end
          end
        end
        S_SHIFT: begin
          // losing write_enable abandons the partial word but keeps the frame position
          if (!w_we) begin
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end else if (w_strobe) begin
            r_word[r_bit_cnt] <= w_data;
            if (r_bit_cnt == BW'(PW - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= S_CLASSIFY;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        S_CLASSIFY: begin
          r_mask[r_pix_idx] <= w_hand;
`ifdef HAND_COUNT_EN
          if (w_hand && r_hand_count != CW'(NPIX))
            r_hand_count <= r_hand_count + CW'(1);
`endif
          if (w_last) begin
            r_frame_done <= 1'b1;
            r_pix_idx    <= '0;
            r_bit_cnt    <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_pix_idx <= r_pix_idx + AW'(1);
            r_state   <= S_SHIFT;
            if (w_strobe) begin
              r_word[0] <= w_data;
              r_bit_cnt <= BW'(1);
            end else begin
              r_bit_cnt <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Nonblocking read of r_mask gives the pre-write value on a same-cycle collision.
  always_ff @(posedge i_fpga_clk) begin
    if (i_rst) r_rd_bit <= 1'b0;
    else       r_rd_bit <= (i_rd_addr < AW'(NPIX)) ? r_mask[i_rd_addr] : 1'b0;
  end

  assign o_rd_bit     = r_rd_bit;
  assign o_pix_idx    = r_pix_idx;
  assign o_frame_done = r_frame_done;

endmodule
